sram_req_arbiter: RTL and testbench

- Shares one in-order SRAM-like memory port between the IF-stage instruction requester and the EX/MEM-stage data requester.
- Arbitrates request/addr_ok, locks the grant until the address is accepted, and keeps an order FIFO of granted requester IDs.
- Routes each data_ok/rdata back to the requester that owns it. This lets the MEM stage's data_sram_data_ok/rdata wait logic work unchanged.
- Sits between the pipeline's inst_sram/data_sram interfaces and the SRAM-to-AXI bridge.

---
 rtl/sram_req_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter
// Purpose  : Shares one in-order SRAM-like memory port between the IF-stage
//            instruction requester and the EX/MEM-stage data requester.
//            Arbitrates req/addr_ok, locks the grant until the address is
//            accepted, and keeps an order FIFO of granted requester IDs so
//            each in-order data_ok/rdata is routed back to its owner.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            inst_* / data_*   - two SRAM-like requester interfaces
//            mem_*             - shared SRAM-like port towards the bridge
//            ost_cnt           - outstanding (accepted, unanswered) count
//            arb_err           - sticky protocol error flag
// Options  : ARB_RR_EN - round-robin selection when both sides request
//            (default build: fixed data-over-instruction priority)
// Revision : 1.0 - initial release
// ============================================================================
module sram_req_arbiter #(
    parameter int OST_DEPTH = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    // instruction side
    input  logic                         inst_req,
    input  logic                         inst_wr,
    input  logic [1:0]                   inst_size,
    input  logic [3:0]                   inst_wstrb,
    input  logic [ADDR_W-1:0]            inst_addr,
    input  logic [DATA_W-1:0]            inst_wdata,
    output logic                         inst_addr_ok,
    output logic                         inst_data_ok,
    output logic [DATA_W-1:0]            inst_rdata,
    // data side
    input  logic                         data_req,
    input  logic                         data_wr,
    input  logic [1:0]                   data_size,
    input  logic [3:0]                   data_wstrb,
    input  logic [ADDR_W-1:0]            data_addr,
    input  logic [DATA_W-1:0]            data_wdata,
    output logic                         data_addr_ok,
    output logic                         data_data_ok,
    output logic [DATA_W-1:0]            data_rdata,
    // shared memory port
    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [3:0]                   mem_wstrb,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [DATA_W-1:0]            mem_rdata,
    // status
    output logic [$clog2(OST_DEPTH):0]   ost_cnt,
    output logic                         arb_err
);

    localparam int c_PTR_W = $clog2(OST_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        c_ST_IDLE   = 2'd0,
        c_ST_LOCK_I = 2'd1,
        c_ST_LOCK_D = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [OST_DEPTH-1:0] r_ids_q,   w_ids_d;
    logic [c_PTR_W-1:0]   r_wptr_q,  w_wptr_d;
    logic [c_PTR_W-1:0]   r_rptr_q,  w_rptr_d;
    logic [c_CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic                 r_err_q,   w_err_d;
`ifdef ARB_RR_EN
    logic                 r_last_q,  w_last_d;   // 0 = I, 1 = D
`endif

    logic w_gnt_id;     // granted side: 0 = I, 1 = D
    logic w_gnt_req;    // request level of the granted side
    logic w_full;
    logic w_empty;
    logic w_mem_req;
    logic w_push;
    logic w_resp;
    logic w_head;

    // ------------------------------------------------------------------
    // Grant selection: a lock pins the owner; otherwise pick a side.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_id  = 1'b0;
        w_gnt_req = 1'b0;
        case (r_state_q)
            c_ST_LOCK_I: begin
                w_gnt_id  = 1'b0;
                w_gnt_req = inst_req;
            end
            c_ST_LOCK_D: begin
                w_gnt_id  = 1'b1;
                w_gnt_req = data_req;
            end
            default: begin
`ifdef ARB_RR_EN
                if (data_req && inst_req) begin
                    w_gnt_id = ~r_last_q;
                end else begin
                    w_gnt_id = data_req;
                end
`else
                w_gnt_id  = data_req;
`endif
                w_gnt_req = data_req | inst_req;
            end
        endcase
    end

    assign w_full    = (r_cnt_q == c_CNT_W'(OST_DEPTH));
    assign w_empty   = (r_cnt_q == '0);
    // Full blocks new requests even if a pop lands in the same cycle.
    assign w_mem_req = w_gnt_req & ~w_full & ~reset;
    assign w_push    = w_mem_req & mem_addr_ok;
    assign w_resp    = mem_data_ok & ~w_empty & ~reset;
    assign w_head    = r_ids_q[r_rptr_q];

    // ------------------------------------------------------------------
    // Shared request mux: everything is zero while no request is issued.
    // ------------------------------------------------------------------
    assign mem_req   = w_mem_req;
    assign mem_wr    = w_mem_req & (w_gnt_id ? data_wr : inst_wr);
    assign mem_size  = w_mem_req ? (w_gnt_id ? data_size  : inst_size)  : 2'b0;
    assign mem_wstrb = w_mem_req ? (w_gnt_id ? data_wstrb : inst_wstrb) : 4'b0;
    assign mem_addr  = w_mem_req ? (w_gnt_id ? data_addr  : inst_addr)  : '0;
    assign mem_wdata = w_mem_req ? (w_gnt_id ? data_wdata : inst_wdata) : '0;

    assign inst_addr_ok = w_push & ~w_gnt_id;
    assign data_addr_ok = w_push &  w_gnt_id;

    // Responses come back in order; the FIFO head names the owner.
    assign inst_data_ok = w_resp & ~w_head;
    assign data_data_ok = w_resp &  w_head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign ost_cnt = r_cnt_q;
    assign arb_err = r_err_q;

    // ------------------------------------------------------------------
    // Grant FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_mem_req && !mem_addr_ok) begin
                    w_state_d = w_gnt_id ? c_ST_LOCK_D : c_ST_LOCK_I;
                end
            end
            c_ST_LOCK_I, c_ST_LOCK_D: begin
                // A dropped req leaves the lock in place until a handshake.
                if (w_push) begin
                    w_state_d = c_ST_IDLE;
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Order FIFO, occupancy and error tracking
    // ------------------------------------------------------------------
    always_comb begin
        w_ids_d  = r_ids_q;
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        if (w_push) begin
            w_ids_d[r_wptr_q] = w_gnt_id;
            w_wptr_d          = r_wptr_q + {{(c_PTR_W-1){1'b0}}, 1'b1};
        end
        if (w_resp) begin
            w_rptr_d = r_rptr_q + {{(c_PTR_W-1){1'b0}}, 1'b1};
        end
        w_cnt_d = r_cnt_q + {{(c_CNT_W-1){1'b0}}, w_push}
                          - {{(c_CNT_W-1){1'b0}}, w_resp};
        // Orphan response, or address accept with no request outstanding.
        w_err_d = r_err_q | (mem_data_ok & w_empty) | (mem_addr_ok & ~w_mem_req);
`ifdef ARB_RR_EN
        w_last_d = w_push ? w_gnt_id : r_last_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= c_ST_IDLE;
            r_ids_q   <= '0;
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
`ifdef ARB_RR_EN
            r_last_q  <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_ids_q   <= w_ids_d;
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_cnt_q   <= w_cnt_d;
            r_err_q   <= w_err_d;
`ifdef ARB_RR_EN
            r_last_q  <= w_last_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_req_arbiter
// Purpose  : Randomized self-checking bench for sram_req_arbiter. Two
//            requester models and an in-order memory model drive the DUT;
//            expected responses are queued at address acceptance and a
//            separate monitor pops and compares them as responses appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

    localparam int OST_DEPTH = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = $clog2(OST_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              inst_req, inst_wr, data_req, data_wr;
    logic [1:0]        inst_size, data_size, mem_size;
    logic [3:0]        inst_wstrb, data_wstrb, mem_wstrb;
    logic [ADDR_W-1:0] inst_addr, data_addr, mem_addr;
    logic [DATA_W-1:0] inst_wdata, data_wdata, mem_wdata;
    logic              inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [DATA_W-1:0] inst_rdata, data_rdata, mem_rdata;
    logic              mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [CNT_W-1:0]  ost_cnt;
    logic              arb_err;

    sram_req_arbiter #(.OST_DEPTH(OST_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .ost_cnt(ost_cnt), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          side;   // 0 = inst, 1 = data
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];      // expected responses, in issue order
    logic [31:0] mem_q[$];   // addresses held by the memory model

    int n_checks = 0;
    int n_pass   = 0;

    // requester model state, index 0 = inst, 1 = data
    bit          busy[2];
    bit          done[2];
    logic        rq_wr[2];
    logic [1:0]  rq_size[2];
    logic [3:0]  rq_wstrb[2];
    logic [31:0] rq_addr[2];
    logic [31:0] rq_wdata[2];

    int  owner      = -1;    // side whose presented request is still pending
    int  last_side  = 0;     // side of the most recent accepted request
    bit  popped_now = 1'b0;
    bit  gen_en     = 1'b0;
    bit  force_dok  = 1'b0;
    bit  expect_err = 1'b0;
    bit  mon_en     = 1'b0;
    int  req_pct    = 40;
    int  aok_pct    = 60;
    int  dok_pct    = 30;

    // Memory content is a fixed function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h02800C0C;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Response monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (mem_data_ok) begin
                if (sb.size() == 0) begin
                    check("orphan_inst_data_ok", inst_data_ok, 0);
                    check("orphan_data_data_ok", data_data_ok, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    popped_now = 1'b1;
                    check("inst_data_ok", inst_data_ok, (e.side == 0));
                    check("data_data_ok", data_data_ok, (e.side == 1));
                    if (e.side == 0) check("inst_rdata", inst_rdata, e.rdata);
                    else             check("data_rdata", data_rdata, e.rdata);
                end
            end else begin
                check("idle_data_ok", {inst_data_ok, data_data_ok}, 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // One clock of stimulus plus address-phase checks.
    // ------------------------------------------------------------------
    task automatic step();
        int   occ;
        int   ps;
        bit   pm;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (done[s]) begin
                busy[s] = 1'b0;
                done[s] = 1'b0;
            end
            if (!busy[s] && gen_en && ($urandom_range(99) < req_pct)) begin
                busy[s]     = 1'b1;
                rq_wr[s]    = (s == 1) ? 1'($urandom_range(1)) : 1'b0;
                rq_size[s]  = 2'($urandom_range(2));
                rq_wstrb[s] = 4'($urandom);
                rq_addr[s]  = $urandom;
                rq_wdata[s] = $urandom;
            end
        end
        inst_req   = busy[0];
        inst_wr    = rq_wr[0];
        inst_size  = rq_size[0];
        inst_wstrb = rq_wstrb[0];
        inst_addr  = rq_addr[0];
        inst_wdata = rq_wdata[0];
        data_req   = busy[1];
        data_wr    = rq_wr[1];
        data_size  = rq_size[1];
        data_wstrb = rq_wstrb[1];
        data_addr  = rq_addr[1];
        data_wdata = rq_wdata[1];
        mem_data_ok = force_dok ||
                      ((mem_q.size() > 0) && ($urandom_range(99) < dok_pct));
        mem_rdata   = (mem_data_ok && mem_q.size() > 0) ? mem_fn(mem_q[0]) : $urandom;
        #1;
        mem_addr_ok = mem_req && ($urandom_range(99) < aok_pct);

        @(negedge clk);
        #1;
        occ = sb.size() + int'(popped_now);
        popped_now = 1'b0;
        check("ost_cnt", ost_cnt, occ);
        check("arb_err", arb_err, expect_err);

        // expected grant
        if (owner >= 0)            ps = owner;
        else if (busy[0] && busy[1]) begin
`ifdef ARB_RR_EN
            ps = 1 - last_side;
`else
            ps = 1;
`endif
        end
        else if (busy[1])          ps = 1;
        else if (busy[0])          ps = 0;
        else                       ps = -1;
        pm = (ps >= 0) && (occ < OST_DEPTH);

        check("mem_req", mem_req, pm);
        if (pm) begin
            check("mem_ctl",   {mem_wr, mem_size, mem_wstrb}, {rq_wr[ps], rq_size[ps], rq_wstrb[ps]});
            check("mem_addr",  mem_addr,  rq_addr[ps]);
            check("mem_wdata", mem_wdata, rq_wdata[ps]);
        end else begin
            check("mem_idle_zero", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata[24:0]}, 0);
        end
        check("inst_addr_ok", inst_addr_ok, pm && mem_addr_ok && ps == 0);
        check("data_addr_ok", data_addr_ok, pm && mem_addr_ok && ps == 1);

        if (pm && mem_addr_ok) begin
            exp_t e;
            e.side  = ps;
            e.rdata = mem_fn(rq_addr[ps]);
            sb.push_back(e);
            done[ps]  = 1'b1;
            owner     = -1;
            last_side = ps;
        end else if (pm) begin
            owner = ps;
        end

        // memory model bookkeeping
        if (mem_req && mem_addr_ok) mem_q.push_back(mem_addr);
        if (mem_data_ok && mem_q.size() > 0) void'(mem_q.pop_front());
        if (force_dok) expect_err = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        inst_req    = 1'b1;   // requests and handshakes during reset
        data_req    = 1'b1;   // must not leak to any output
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        for (int s = 0; s < 2; s++) begin
            busy[s] = 1'b0;
            done[s] = 1'b0;
        end
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check("rst_outputs", {mem_req, inst_addr_ok, data_addr_ok,
                                  inst_data_ok, data_data_ok}, 0);
            @(posedge clk);
            #1;
        end
        reset       = 1'b0;
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        sb.delete();
        mem_q.delete();
        owner      = -1;
        last_side  = 0;
        popped_now = 1'b0;
        expect_err = 1'b0;
        @(negedge clk);
        check("post_rst_ost_cnt", ost_cnt, 0);
        check("post_rst_arb_err", arb_err, 0);
    endtask

    task automatic drain();
        int k;
        gen_en  = 1'b0;
        aok_pct = 100;
        dok_pct = 100;
        k = 0;
        while ((sb.size() > 0 || busy[0] || busy[1]) && k < 300) begin
            step();
            k++;
        end
        check("drain_done", sb.size() + int'(busy[0]) + int'(busy[1]), 0);
    endtask

    initial begin
        reset = 1'b0;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b0; inst_wstrb = 4'b0;
        inst_addr = '0;  inst_wdata = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'b0; data_wstrb = 4'b0;
        data_addr = '0;  data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        for (int s = 0; s < 2; s++) begin
            busy[s] = 1'b0; done[s] = 1'b0; rq_wr[s] = 1'b0; rq_size[s] = 2'b0;
            rq_wstrb[s] = 4'b0; rq_addr[s] = '0; rq_wdata[s] = '0;
        end

        do_reset(3);
        mon_en = 1'b1;

        // slow memory: builds up to full and exercises locking
        gen_en = 1'b1; req_pct = 70; aok_pct = 50; dok_pct = 10;
        for (int k = 0; k < 1500; k++) step();
        // fast memory: frequent simultaneous push/pop
        req_pct = 40; aok_pct = 70; dok_pct = 60;
        for (int k = 0; k < 1500; k++) step();
        // heavy contention, always-accepting memory
        req_pct = 100; aok_pct = 100; dok_pct = 50;
        for (int k = 0; k < 500; k++) step();
        drain();

        // orphan response: error flag, nothing forwarded
        force_dok = 1'b1;
        step();
        force_dok = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // two transactions in flight, then reset clears everything
        do_reset(1);
        gen_en = 1'b1; req_pct = 100; aok_pct = 100; dok_pct = 0;
        for (int k = 0; k < 20 && sb.size() < 2; k++) step();
        gen_en = 1'b0;
        check("inflight_before_reset", sb.size(), 2);
        do_reset(1);
        for (int k = 0; k < 5; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
